// File: rtl/obi_bounded_responder.sv
// OBI responder that shapes random gnt/rvalid/rdata stimulus into legal, bounded-latency responses.
// Optional request-stability checker enabled by defining OBI_PROTOCOL_CHECK_EN.
`ifndef ADDRESS_WD
`define ADDRESS_WD 32
`endif

module obi_bounded_responder #(
    parameter int unsigned ADDR_WD         = `ADDRESS_WD,
    parameter int unsigned DATA_WD         = 64,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned GNT_TIMEOUT     = 5,
    parameter int unsigned RSP_TIMEOUT     = 5
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               req_i,
    input  logic [ADDR_WD-1:0]                 addr_i,
    input  logic                               we_i,
    input  logic [DATA_WD/8-1:0]               be_i,
    input  logic [DATA_WD-1:0]                 wdata_i,
    input  logic                               rand_gnt_i,
    input  logic                               rand_rvalid_i,
    input  logic [DATA_WD-1:0]                 rand_rdata_i,
    output logic                               gnt_o,
    output logic                               rvalid_o,
    output logic [DATA_WD-1:0]                 rdata_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                               proto_err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned GW = (GNT_TIMEOUT > 0) ? $clog2(GNT_TIMEOUT + 1) : 1;
    localparam int unsigned RW = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic          r_we_q [MAX_OUTSTANDING];
    logic [GW-1:0] r_gnt_wait;
    logic [RW-1:0] r_rsp_wait;

    logic w_full;
    logic w_empty;
    logic w_gnt;
    logic w_rvalid;
    logic w_gnt_timeout;
    logic w_rsp_timeout;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full        = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty       = (r_count == '0);
    assign w_gnt_timeout = (r_gnt_wait == GW'(GNT_TIMEOUT));
    assign w_rsp_timeout = (r_rsp_wait == RW'(RSP_TIMEOUT));

    assign w_rvalid = ~reset & ~w_empty & (rand_rvalid_i | w_rsp_timeout);
    // A pop in the same cycle frees the slot, so a full queue may still grant.
    assign w_gnt    = ~reset & req_i & (~w_full | w_rvalid) & (rand_gnt_i | w_gnt_timeout);

    assign gnt_o         = w_gnt;
    assign rvalid_o      = w_rvalid;
    assign rdata_o       = (w_rvalid & ~r_we_q[r_head]) ? rand_rdata_i : '0;
    assign outstanding_o = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_gnt_wait <= '0;
            r_rsp_wait <= '0;
        end else begin
            if (w_gnt) begin
                r_tail <= f_next(r_tail);
            end
            if (w_rvalid) begin
                r_head <= f_next(r_head);
            end
            case ({w_gnt, w_rvalid})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_gnt || !req_i) begin
                r_gnt_wait <= '0;
            end else if (!w_gnt_timeout) begin
                r_gnt_wait <= r_gnt_wait + GW'(1);
            end

            if (w_rvalid) begin
                r_rsp_wait <= '0;
            end else if (!w_empty && !w_rsp_timeout) begin
                r_rsp_wait <= r_rsp_wait + RW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                r_we_q[i] <= 1'b0;
            end
        end else if (w_gnt) begin
            r_we_q[r_tail] <= we_i;
        end
    end

`ifdef OBI_PROTOCOL_CHECK_EN
    logic                 r_stalled;
    logic                 r_proto_err;
    logic [ADDR_WD-1:0]   r_lat_addr;
    logic                 r_lat_we;
    logic [DATA_WD/8-1:0] r_lat_be;
    logic [DATA_WD-1:0]   r_lat_wdata;
    logic                 w_stall;
    logic                 w_err;

    assign w_stall = req_i & ~w_gnt;
    // Fields are compared against the snapshot from the first stalled cycle until the grant.
    assign w_err   = r_stalled & (~req_i | (addr_i != r_lat_addr) | (we_i != r_lat_we) |
                                  (be_i != r_lat_be) | (wdata_i != r_lat_wdata));
    assign proto_err_o = r_proto_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stalled   <= 1'b0;
            r_proto_err <= 1'b0;
            r_lat_addr  <= '0;
            r_lat_we    <= 1'b0;
            r_lat_be    <= '0;
            r_lat_wdata <= '0;
        end else begin
            r_stalled   <= w_stall;
            r_proto_err <= r_proto_err | w_err;
            if (w_stall && !r_stalled) begin
                r_lat_addr  <= addr_i;
                r_lat_we    <= we_i;
                r_lat_be    <= be_i;
                r_lat_wdata <= wdata_i;
            end
        end
    end

`ifdef FORMAL
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (r_gnt_wait <= GW'(GNT_TIMEOUT));
            assert (r_count <= CW'(MAX_OUTSTANDING));
        end
    end
`endif
`else
    logic w_unused;
    assign w_unused    = ^{addr_i, be_i, wdata_i};
    assign proto_err_o = 1'b0;
`endif

endmodule
